// File: rtl/rv_axi4_lite_arbiter.sv
// rv_axi4_lite_arbiter
//   Shares one AXI4-Lite slave between two masters (s0, s1). The read and write
//   directions each have their own FSM and grant register, and each direction
//   allows one outstanding transaction. A response returns to the master that
//   issued the request.
//
//   Optional feature macro: RV_AXI4_LITE_ARBITER_ROUND_ROBIN_EN
//     defined   : round-robin between the masters using a last-grant register
//                 per direction (reset to 1, so master 0 wins first).
//     undefined : fixed priority. Master 0 always wins contention.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   sN_ar*/sN_r*             master N read address / read data channels
//   sN_aw*/sN_w*/sN_b*       master N write address / data / response channels
//   m_ar*/m_aw*/m_w*         shared slave request channels (outputs)
//   m_r*/m_b*                shared slave response channels (inputs)
//
// State table
//   R_IDLE | no read in flight; arbitrate AR requests
//   R_ADDR | granted master's AR forwarded to the slave
//   R_RESP | slave R routed back to the granted master
//   W_IDLE | no write in flight; arbitrate AW/W requests
//   W_REQ  | granted master's AW and W forwarded; done flags track handshakes
//   W_RESP | slave B routed back to the granted master

module rv_axi4_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // master 0
    input  logic                    s0_arvalid_i,
    output logic                    s0_arready_o,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr_i,
    input  logic [2:0]              s0_arprot_i,
    output logic                    s0_rvalid_o,
    input  logic                    s0_rready_i,
    output logic [DATA_WIDTH-1:0]   s0_rdata_o,
    output logic [1:0]              s0_rresp_o,
    input  logic                    s0_awvalid_i,
    output logic                    s0_awready_o,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr_i,
    input  logic [2:0]              s0_awprot_i,
    input  logic                    s0_wvalid_i,
    output logic                    s0_wready_o,
    input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb_i,
    output logic                    s0_bvalid_o,
    input  logic                    s0_bready_i,
    output logic [1:0]              s0_bresp_o,
    // master 1
    input  logic                    s1_arvalid_i,
    output logic                    s1_arready_o,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr_i,
    input  logic [2:0]              s1_arprot_i,
    output logic                    s1_rvalid_o,
    input  logic                    s1_rready_i,
    output logic [DATA_WIDTH-1:0]   s1_rdata_o,
    output logic [1:0]              s1_rresp_o,
    input  logic                    s1_awvalid_i,
    output logic                    s1_awready_o,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr_i,
    input  logic [2:0]              s1_awprot_i,
    input  logic                    s1_wvalid_i,
    output logic                    s1_wready_o,
    input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb_i,
    output logic                    s1_bvalid_o,
    input  logic                    s1_bready_i,
    output logic [1:0]              s1_bresp_o,
    // shared slave
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [2:0]              m_awprot_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    input  logic [1:0]              m_bresp_i
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      rd_grant_q, rd_grant_d;
    logic      wr_grant_q, wr_grant_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;

    logic      s0_wr_req, s1_wr_req;
    logic      rd_req, wr_req;
    logic      rd_pick, wr_pick;
    logic      aw_hs, w_hs, aw_fin, w_fin;

    assign s0_wr_req = s0_awvalid_i | s0_wvalid_i;
    assign s1_wr_req = s1_awvalid_i | s1_wvalid_i;
    assign rd_req    = s0_arvalid_i | s1_arvalid_i;
    assign wr_req    = s0_wr_req | s1_wr_req;

`ifdef RV_AXI4_LITE_ARBITER_ROUND_ROBIN_EN
    logic rd_last_q, wr_last_q;

    // Under contention the master not granted last time wins.
    assign rd_pick = (s0_arvalid_i && s1_arvalid_i) ? ~rd_last_q : s1_arvalid_i;
    assign wr_pick = (s0_wr_req && s1_wr_req) ? ~wr_last_q : s1_wr_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_last_q <= 1'b1;
            wr_last_q <= 1'b1;
        end else begin
            if (rd_state_q == R_IDLE && rd_req) rd_last_q <= rd_pick;
            if (wr_state_q == W_IDLE && wr_req) wr_last_q <= wr_pick;
        end
    end
`else
    assign rd_pick = ~s0_arvalid_i & s1_arvalid_i;
    assign wr_pick = ~s0_wr_req & s1_wr_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_grant_q <= 1'b0;
            wr_grant_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_grant_q <= rd_grant_d;
            wr_grant_q <= wr_grant_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Read direction
    assign m_arvalid_o  = (rd_state_q == R_ADDR) && (rd_grant_q ? s1_arvalid_i : s0_arvalid_i);
    assign m_araddr_o   = rd_grant_q ? s1_araddr_i : s0_araddr_i;
    assign m_arprot_o   = rd_grant_q ? s1_arprot_i : s0_arprot_i;
    assign s0_arready_o = (rd_state_q == R_ADDR) && !rd_grant_q && m_arready_i;
    assign s1_arready_o = (rd_state_q == R_ADDR) &&  rd_grant_q && m_arready_i;

    assign m_rready_o   = (rd_state_q == R_RESP) && (rd_grant_q ? s1_rready_i : s0_rready_i);
    assign s0_rvalid_o  = (rd_state_q == R_RESP) && !rd_grant_q && m_rvalid_i;
    assign s1_rvalid_o  = (rd_state_q == R_RESP) &&  rd_grant_q && m_rvalid_i;
    assign s0_rdata_o   = m_rdata_i;
    assign s1_rdata_o   = m_rdata_i;
    assign s0_rresp_o   = m_rresp_i;
    assign s1_rresp_o   = m_rresp_i;

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        case (rd_state_q)
            R_IDLE: if (rd_req) begin
                rd_grant_d = rd_pick;
                rd_state_d = R_ADDR;
            end
            R_ADDR: if (m_arvalid_o && m_arready_i) rd_state_d = R_RESP;
            R_RESP: if (m_rvalid_i && m_rready_o)   rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write direction: a channel that has already handshaked is masked off
    // on both sides until the other channel catches up.
    assign m_awvalid_o  = (wr_state_q == W_REQ) && !aw_done_q && (wr_grant_q ? s1_awvalid_i : s0_awvalid_i);
    assign m_wvalid_o   = (wr_state_q == W_REQ) && !w_done_q  && (wr_grant_q ? s1_wvalid_i  : s0_wvalid_i);
    assign m_awaddr_o   = wr_grant_q ? s1_awaddr_i : s0_awaddr_i;
    assign m_awprot_o   = wr_grant_q ? s1_awprot_i : s0_awprot_i;
    assign m_wdata_o    = wr_grant_q ? s1_wdata_i  : s0_wdata_i;
    assign m_wstrb_o    = wr_grant_q ? s1_wstrb_i  : s0_wstrb_i;
    assign s0_awready_o = (wr_state_q == W_REQ) && !aw_done_q && !wr_grant_q && m_awready_i;
    assign s1_awready_o = (wr_state_q == W_REQ) && !aw_done_q &&  wr_grant_q && m_awready_i;
    assign s0_wready_o  = (wr_state_q == W_REQ) && !w_done_q  && !wr_grant_q && m_wready_i;
    assign s1_wready_o  = (wr_state_q == W_REQ) && !w_done_q  &&  wr_grant_q && m_wready_i;

    assign m_bready_o   = (wr_state_q == W_RESP) && (wr_grant_q ? s1_bready_i : s0_bready_i);
    assign s0_bvalid_o  = (wr_state_q == W_RESP) && !wr_grant_q && m_bvalid_i;
    assign s1_bvalid_o  = (wr_state_q == W_RESP) &&  wr_grant_q && m_bvalid_i;
    assign s0_bresp_o   = m_bresp_i;
    assign s1_bresp_o   = m_bresp_i;

    assign aw_hs  = m_awvalid_o && m_awready_i;
    assign w_hs   = m_wvalid_o && m_wready_i;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: if (wr_req) begin
                wr_grant_d = wr_pick;
                wr_state_d = W_REQ;
            end
            W_REQ: begin
                if (aw_fin && w_fin) begin
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_RESP;
                end else begin
                    aw_done_d  = aw_fin;
                    w_done_d   = w_fin;
                end
            end
            W_RESP: if (m_bvalid_i && m_bready_o) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

endmodule
